// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer with baud timing, optional parity and 1 or 2 stop bits
module uart_tx_framer #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 868,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
   localparam logic              STOP_LAST = (STOP_BITS == 2);
   localparam logic              PAR_SEED  = (PARITY_ODD != 0);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  stop_q, stop_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  parity_q, parity_d;
   logic                  tx_q, tx_d;
   logic                  tx_ready_q, tx_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  boundary;

   assign boundary = (baud_q == BAUD_LAST);

   // Next-state values also choose the next line level, so tx is a pure flop output.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      stop_d     = stop_q;
      shreg_d    = shreg_q;
      parity_d   = parity_q;
      tx_d       = tx_q;
      tx_ready_d = tx_ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      if (state_q != S_IDLE) begin
         baud_d = boundary ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            tx_d       = 1'b1;
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
            if (tx_valid && tx_ready_q) begin
               shreg_d    = tx_data;
               parity_d   = PAR_SEED;
               baud_d     = '0;
               state_d    = S_START;
               tx_d       = 1'b0;
               tx_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         S_START: begin
            if (boundary) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = shreg_q[0];
            end
         end
         S_DATA: begin
            if (boundary) begin
               shreg_d  = shreg_q >> 1;
               parity_d = parity_q ^ shreg_q[0];
               bit_d    = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  if (PARITY_EN != 0) begin
                     state_d = S_PARITY;
                     tx_d    = parity_d;
                  end else begin
                     state_d = S_STOP;
                     stop_d  = 1'b0;
                     tx_d    = 1'b1;
                  end
               end else begin
                  tx_d = shreg_d[0];
               end
            end
         end
         S_PARITY: begin
            if (boundary) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (boundary) begin
               if (stop_q == STOP_LAST) begin
                  state_d    = S_IDLE;
                  done_d     = 1'b1;
                  tx_ready_d = 1'b1;
                  busy_d     = 1'b0;
                  tx_d       = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         stop_q     <= 1'b0;
         shreg_q    <= '0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         stop_q     <= stop_d;
         shreg_q    <= shreg_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer: 8N1, 8E2 and 8O1 instances at CLK_DIV=4
module tb_uart_tx_framer;

   localparam int CD = 4;

   logic            clk;
   logic            rst;
   logic [2:0]      valid;
   logic [2:0][7:0] data;
   wire  [2:0]      txl;
   wire  [2:0]      ready;
   wire  [2:0]      busy;
   wire  [2:0]      done;

   int checks = 0;
   int errors = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];

   int         m_cyc[3]    = '{-1, -1, -1};
   int         frames[3]   = '{0, 0, 0};
   int         done_cnt[3] = '{0, 0, 0};
   logic [7:0] m_exp[3];
   logic [CD-1:0] m_samp[3];
   logic       m_bad[3];
   int         bit_i, ph, nb;

   uart_tx_framer #(.DATA_WIDTH(8), .CLK_DIV(CD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
      .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]),
      .tx_ready(ready[0]), .tx(txl[0]), .busy(busy[0]), .done(done[0]));

   uart_tx_framer #(.DATA_WIDTH(8), .CLK_DIV(CD), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_e2 (
      .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]),
      .tx_ready(ready[1]), .tx(txl[1]), .busy(busy[1]), .done(done[1]));

   uart_tx_framer #(.DATA_WIDTH(8), .CLK_DIV(CD), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
      .clk(clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]),
      .tx_ready(ready[2]), .tx(txl[2]), .busy(busy[2]), .done(done[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic int pen(input int k);
      return (k != 0) ? 1 : 0;
   endfunction

   function automatic int stops(input int k);
      return (k == 1) ? 2 : 1;
   endfunction

   function automatic logic podd(input int k);
      return (k == 2);
   endfunction

   function automatic logic exp_bit(input int k, input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (pen(k) == 1 && i == 9) return (^b) ^ podd(k);
      return 1'b1;
   endfunction

   function automatic int qsize(input int k);
      case (k)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic void qpush(input int k, input logic [7:0] b);
      case (k)
         0: q0.push_back(b);
         1: q1.push_back(b);
         default: q2.push_back(b);
      endcase
   endfunction

   function automatic logic [7:0] qpop(input int k);
      logic [7:0] v;
      v = 8'h00;
      case (k)
         0: if (q0.size() > 0) v = q0.pop_front();
         1: if (q1.size() > 0) v = q1.pop_front();
         default: if (q2.size() > 0) v = q2.pop_front();
      endcase
      return v;
   endfunction

   // Expected byte is captured on the accept edge, before the DUT has reacted.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst && valid[k] && ready[k]) qpush(k, data[k]);
      end
   end

   // Line monitor: every bit must hold its level for CD cycles; done lands right after the last stop bit.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (done[k] === 1'b1) done_cnt[k]++;
         if (!rst) begin
            m_cyc[k] = -1;
         end else begin
            if (m_cyc[k] < 0 && txl[k] === 1'b0) begin
               chk($sformatf("sb_nonempty%0d", k), 32'(qsize(k) > 0), 32'd1);
               m_exp[k] = qpop(k);
               m_cyc[k] = 0;
            end
            if (m_cyc[k] >= 0) begin
               bit_i = m_cyc[k] / CD;
               ph    = m_cyc[k] % CD;
               nb    = 1 + 8 + pen(k) + stops(k);
               if (bit_i < nb) begin
                  if (ph == 0) m_bad[k] = 1'b0;
                  m_samp[k] = {m_samp[k][CD-2:0], txl[k]};
                  if (ready[k] !== 1'b0 || busy[k] !== 1'b1 || done[k] !== 1'b0) m_bad[k] = 1'b1;
                  if (ph == CD - 1) begin
                     chk($sformatf("frame%0d_bit%0d", k, bit_i), 32'(m_samp[k]),
                         32'({CD{exp_bit(k, m_exp[k], bit_i)}}));
                     chk($sformatf("frame%0d_status%0d", k, bit_i), 32'(m_bad[k]), 32'd0);
                  end
                  m_cyc[k]++;
               end else begin
                  chk($sformatf("frame%0d_end", k), 32'({txl[k], done[k], ready[k], busy[k]}), 32'b1110);
                  frames[k]++;
                  m_cyc[k] = -1;
               end
            end
         end
      end
   end

   task automatic wait_frames(input int k, input int n);
      for (int i = 0; i < 400 && frames[k] < n; i++) @(posedge clk);
      chk($sformatf("frame_wait%0d", k), 32'(frames[k] >= n), 32'd1);
   endtask

   task automatic send(input int k, input logic [7:0] b);
      int i;
      @(negedge clk);
      data[k]  = b;
      valid[k] = 1'b1;
      i = 0;
      while (ready[k] !== 1'b1 && i < 200) begin
         @(negedge clk);
         i++;
      end
      chk($sformatf("accept_wait%0d", k), 32'(ready[k]), 32'd1);
      @(negedge clk);
      valid[k] = 1'b0;
      chk($sformatf("start_latency%0d", k), 32'({txl[k], ready[k], busy[k]}), 32'b001);
   endtask

   initial begin
      int n, d;
      rst   = 1'b0;
      valid = '0;
      data  = '0;
      data[0]  = 8'hA5;
      valid[0] = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset_idle%0d", k), 32'({txl[k], ready[k], busy[k], done[k]}), 32'b1100);

      rst = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      chk("release_accept", 32'({txl[0], ready[0], busy[0]}), 32'b001);
      wait_frames(0, 1);

      send(1, 8'hA5);
      wait_frames(1, 1);
      send(2, 8'hA5);
      wait_frames(2, 1);
      send(1, 8'h01);
      wait_frames(1, 2);

      n = frames[1];
      d = done_cnt[1];
      @(negedge clk);
      data[1]  = 8'h3C;
      valid[1] = 1'b1;
      @(negedge clk);
      chk("b2b_first_start", 32'(txl[1]), 32'd0);
      data[1] = 8'hC3;
      wait_frames(1, n + 1);
      @(negedge clk);
      chk("b2b_gap", 32'({txl[1], busy[1]}), 32'b01);
      valid[1] = 1'b0;
      wait_frames(1, n + 2);
      repeat (4) @(negedge clk);
      chk("b2b_done_pulses", 32'(done_cnt[1] - d), 32'd2);

      n = frames[0];
      send(0, 8'h5A);
      repeat (10) @(negedge clk);
      data[0]  = 8'hFF;
      valid[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("midframe_ready", 32'(ready[0]), 32'd0);
      valid[0] = 1'b0;
      wait_frames(0, n + 1);

      send(0, 8'h00);
      repeat (17) @(negedge clk);
      chk("abort_pre_tx", 32'(txl[0]), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("abort_async", 32'({txl[0], ready[0], busy[0], done[0]}), 32'b1100);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      n = frames[0];
      send(0, 8'hFF);
      wait_frames(0, n + 1);

      n = frames[2];
      for (int i = 0; i < 3; i++) begin
         send(2, 8'($urandom_range(0, 255)));
         wait_frames(2, n + i + 1);
      end

      repeat (4) @(negedge clk);
      for (int k = 0; k < 3; k++)
         chk($sformatf("sb_empty%0d", k), 32'(qsize(k)), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Transmit-side UART framer and bit-timing controller. It accepts a parallel byte over a valid/ready handshake and generates the baud-rate bit timing. It serialises the frame LSB-first as start bit, data, optional parity, then stop bit(s). The tx output drives the UART TX pin; done and busy go to the peripheral status/interrupt logic.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9)
CLK_DIV, 868, clock cycles per bit period (>=2; 868 = 100 MHz / 115200)
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
tx_data  input  DATA_WIDTH  parallel payload, sampled on handshake
tx_valid  input  1  upstream has a byte
tx_ready  output  1  framer can accept a byte
tx  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (rst=0, async): state=IDLE; tx=1, tx_ready=1, busy=0, done=0; baud counter, bit counter, shift register and parity accumulator cleared. This applies even mid-frame: the line returns to idle-high immediately and the partial frame is abandoned. No resume after release.
- All outputs are registered; tx has no combinational path from inputs.
- Handshake: accept occurs when tx_valid & tx_ready are high on a rising edge. tx_ready=1 only in IDLE. On accept, capture tx_data into the shift register and seed parity with PARITY_ODD. Then: state->START, tx_ready->0, busy->1, baud counter->0. tx_data/tx_valid are ignored while busy.
- Latency: tx goes low on the first cycle after the accept edge.
- Bit timing: every bit (start, data, parity, stop) holds exactly CLK_DIV cycles. The baud counter runs 0..CLK_DIV-1; the bit boundary occurs when count==CLK_DIV-1, and the counter wraps to 0.
- FSM states:
  - IDLE: tx=1.
  - START: tx=0; at boundary -> DATA with bit counter=0.
  - DATA: tx=shreg[0]; at boundary, shift right (zero fill), XOR the outgoing bit into parity, and increment the bit counter. After bit DATA_WIDTH-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx=parity accumulator; at boundary -> STOP.
  - STOP: tx=1; stop counter counts STOP_BITS periods; at the final boundary -> IDLE.
- Even parity: total ones in data+parity is even. Odd parity: total is odd.
- Frame length = CLK_DIV*(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles from the first low cycle to IDLE entry.
- End of frame: on the IDLE-entry edge, done=1 for exactly one cycle, and tx_ready=1, busy=0 from that cycle. A new accept is possible on the next edge, so the minimum inter-frame gap is 1 cycle beyond the stop bits.
- tx_valid held high continuously sends frames back-to-back with that 1-cycle gap; no data is dropped or duplicated.
- Counter widths: baud counter is clog2(CLK_DIV) bits; bit counter is clog2(DATA_WIDTH+1) bits. No overflow is reachable.

Test Plan:
1. Reset: hold rst=0 with tx_valid=1 -> tx=1, tx_ready=1, busy=0, done=0. Release rst: the accept occurs on the first edge after release.
2. CLK_DIV=4, 8N1, send 0xA5 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. done pulses at cycle 40 after the first low cycle; tx_ready returns at the same edge.
3. PARITY_EN=1, send 0xA5 -> parity bit 0 (even). With PARITY_ODD=1 -> parity bit 1. Send 0x01 even -> parity bit 1. Frame = 44 cycles.
4. STOP_BITS=2, tx_valid held high with 0x3C then 0xC3 -> two stop periods (8 cycles high) plus 1 idle cycle, then the second start bit. Both bytes decode correctly; exactly two done pulses.
5. Change tx_data and pulse tx_valid mid-frame -> the frame continues with the originally captured byte; tx_ready stays 0.
6. Assert rst=0 during data bit 3 of 0x00 -> tx=1 asynchronously, state IDLE. After release, send 0xFF -> a clean full frame with no residue.
